// File: rtl/gbe_txpacketbuf_param.sv
// GbE transmit packet buffer: circular byte RAM, committed-length queue, MAC streaming FSM
// with optional short-frame padding and an enforced inter-packet gap.
//
// state    | meaning
// IDLE     | waiting for a committed packet; latches its length from the queue head
// PREFETCH | RAM read of byte 0 in flight
// PRESENT  | byte 0 on mac_txd with mac_txdv high, held until mac_txack
// BYTES    | streaming remaining data/pad bytes, one per cycle
// GAP      | mac_txdv low for IFG_CYCLES cycles before the next packet
module gbe_txpacketbuf_param #(
  parameter int ADDR_W     = 12,
  parameter int LEN_W      = 11,
  parameter int QLOG2      = 3,
  parameter int MAX_LEN    = 1536,
  parameter bit PAD_EN     = 1'b1,
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic             mac_clk,
  input  logic             reset_n,
  input  logic [7:0]       packet_txd,
  input  logic [LEN_W-1:0] packet_addr,
  input  logic             packet_we,
  input  logic [LEN_W-1:0] packet_len,
  input  logic             packet_done,
  output logic             packet_txspace,
  output logic             commit_err,
  output logic [QLOG2:0]   pkts_pending,
  output logic [7:0]       mac_txd,
  output logic             mac_txdv,
  input  logic             mac_txack,
  output logic             tx_busy
);

  localparam int PW       = ADDR_W + 1;
  localparam int CW       = QLOG2 + 1;
  localparam int QDEPTH   = 1 << QLOG2;
  localparam int GAP_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int GAP_LOAD = (IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0;
  localparam bit HAS_GAP  = (IFG_CYCLES > 0);

  localparam logic [PW-1:0]    DEPTH_V  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0]    QDEPTH_V = {1'b1, {QLOG2{1'b0}}};
  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] ONE_L    = LEN_W'(1);

  typedef enum logic [2:0] {IDLE, PREFETCH, PRESENT, BYTES, GAP} state_t;

  state_t           state;
  logic [7:0]       ram [DEPTH_V];
  logic [LEN_W-1:0] q_mem [QDEPTH];
  logic [QLOG2-1:0] q_wp, q_rp;
  logic [CW-1:0]    q_cnt, cnt_nxt;
  logic [PW-1:0]    wr_base, rd_base, wr_nxt, rd_nxt, used, free_b, free_nxt;
  logic [LEN_W-1:0] cur_len, tot_len, idx, rd_idx_nxt;
  logic [GAP_W-1:0] gap_cnt;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [7:0]       byte_nxt;
  logic             len_bad, q_full, too_big, commit_ok, commit_bad, tx_done;

  assign used       = wr_base - rd_base;
  assign free_b     = DEPTH_V - used;
  assign q_full     = (q_cnt == QDEPTH_V);
  assign len_bad    = (packet_len == '0) || (32'(packet_len) > 32'(MAX_LEN));
  assign too_big    = (32'(packet_len) > 32'(free_b));
  assign commit_ok  = packet_done && !len_bad && !q_full && !too_big;
  assign commit_bad = packet_done && !commit_ok;

  // Pad bytes extend the frame on the wire but never consume RAM.
  assign tot_len = (PAD_EN && (cur_len < MIN_L)) ? MIN_L : cur_len;
  assign tx_done = ((state == PRESENT) && mac_txack && (tot_len == ONE_L)) ||
                   ((state == BYTES) && (idx == tot_len - ONE_L));

  assign wr_nxt   = commit_ok ? wr_base + PW'(packet_len) : wr_base;
  assign rd_nxt   = tx_done ? rd_base + PW'(cur_len) : rd_base;
  assign cnt_nxt  = q_cnt + CW'(commit_ok) - CW'(tx_done);
  assign free_nxt = DEPTH_V - (wr_nxt - rd_nxt);

  always_comb begin
    rd_idx_nxt = idx + ONE_L;
    case (state)
      PREFETCH: rd_idx_nxt = '0;
      PRESENT:  rd_idx_nxt = ONE_L;
      default:  rd_idx_nxt = idx + ONE_L;
    endcase
  end

  assign rd_addr  = rd_base[ADDR_W-1:0] + ADDR_W'(rd_idx_nxt);
  assign wr_addr  = wr_base[ADDR_W-1:0] + ADDR_W'(packet_addr);
  assign byte_nxt = (rd_idx_nxt < cur_len) ? ram[rd_addr] : 8'h00;

  always_ff @(posedge mac_clk) begin
    if (packet_we) ram[wr_addr] <= packet_txd;
  end

  always_ff @(posedge mac_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_base        <= '0;
      rd_base        <= '0;
      q_wp           <= '0;
      q_rp           <= '0;
      q_cnt          <= '0;
      commit_err     <= 1'b0;
      packet_txspace <= 1'b1;
      for (int i = 0; i < QDEPTH; i++) q_mem[i] <= '0;
    end else begin
      commit_err     <= commit_bad;
      wr_base        <= wr_nxt;
      rd_base        <= rd_nxt;
      q_cnt          <= cnt_nxt;
      packet_txspace <= (cnt_nxt != QDEPTH_V) && (32'(free_nxt) >= 32'(MAX_LEN));
      if (commit_ok) begin
        q_mem[q_wp] <= packet_len;
        q_wp        <= q_wp + 1'b1;
      end
      if (tx_done) q_rp <= q_rp + 1'b1;
    end
  end

  always_ff @(posedge mac_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cur_len  <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      mac_txd  <= 8'h00;
      mac_txdv <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mac_txdv <= 1'b0;
          if (q_cnt != '0) begin
            cur_len <= q_mem[q_rp];
            state   <= PREFETCH;
          end
        end
        PREFETCH: begin
          mac_txd  <= byte_nxt;
          mac_txdv <= 1'b1;
          state    <= PRESENT;
        end
        PRESENT, BYTES: begin
          if (tx_done) begin
            mac_txdv <= 1'b0;
            mac_txd  <= 8'h00;
            gap_cnt  <= GAP_W'(GAP_LOAD);
            state    <= HAS_GAP ? GAP : IDLE;
          end else if ((state == BYTES) || mac_txack) begin
            idx     <= rd_idx_nxt;
            mac_txd <= byte_nxt;
            state   <= BYTES;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pkts_pending = q_cnt;
  assign tx_busy      = (state != IDLE);

endmodule

// File: tb/tb_gbe_txpacketbuf_param.sv
// Bench for gbe_txpacketbuf_param: table of commits plus hand-built corner sequences,
// with a byte/frame scoreboard checked by a MAC-side monitor.
module tb_gbe_txpacketbuf_param;
  localparam int LEN_W   = 11;
  localparam int QLOG2   = 3;
  localparam int MAX_LEN = 1536;
  localparam int MIN_LEN = 60;
  localparam int IFG     = 12;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [7:0]       packet_txd = '0;
  logic [LEN_W-1:0] packet_addr = '0;
  logic             packet_we = 1'b0;
  logic [LEN_W-1:0] packet_len = '0;
  logic             packet_done = 1'b0;
  logic             packet_txspace, commit_err, mac_txdv, tx_busy;
  logic [QLOG2:0]   pkts_pending;
  logic [7:0]       mac_txd;
  logic             mac_txack = 1'b1;

  always #5 clk = ~clk;

  gbe_txpacketbuf_param dut (
    .mac_clk(clk), .reset_n(reset_n), .packet_txd(packet_txd), .packet_addr(packet_addr),
    .packet_we(packet_we), .packet_len(packet_len), .packet_done(packet_done),
    .packet_txspace(packet_txspace), .commit_err(commit_err), .pkts_pending(pkts_pending),
    .mac_txd(mac_txd), .mac_txdv(mac_txdv), .mac_txack(mac_txack), .tx_busy(tx_busy)
  );

  typedef struct { int len; bit err; int seed; } vec_t;
  vec_t vecs [11];

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_bytes [$];
  int exp_lens [$];
  int wb = 0;
  bit in_frame = 0, presenting = 0, have_prev = 0, next_queued = 0;
  int rx_cnt = 0, low_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((seed * 37 + i) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes in ascending or descending offset order so addressing is exercised, not streaming.
  task automatic write_pkt(input int len, input int seed);
    for (int i = 0; i < len; i++) begin
      int a;
      a = (seed % 2 == 1) ? len - 1 - i : i;
      packet_we   = 1'b1;
      packet_addr = LEN_W'(a);
      packet_txd  = pat(seed, a);
      tick();
    end
    packet_we = 1'b0;
  endtask

  task automatic commit(input int len, input int seed, input bit exp_err);
    if (len >= 1 && len <= MAX_LEN) write_pkt(len, seed);
    packet_len  = LEN_W'(len);
    packet_done = 1'b1;
    tick();
    packet_done = 1'b0;
    check("commit_err", 32'(commit_err), 32'(exp_err));
    if (!exp_err) begin
      for (int i = 0; i < len; i++) exp_bytes.push_back(pat(seed, i));
      for (int i = len; i < MIN_LEN; i++) exp_bytes.push_back(8'h00);
      exp_lens.push_back(len < MIN_LEN ? MIN_LEN : len);
      wb = (wb + len) % 8192;
    end
  endtask

  task automatic wait_txspace();
    int n = 0;
    while (!packet_txspace && n < 20000) begin tick(); n++; end
    check("txspace_wait_timeout", 32'(n >= 20000), 0);
  endtask

  task automatic wait_txdv();
    int n = 0;
    while (!mac_txdv && n < 200) begin tick(); n++; end
    check("txdv_wait_timeout", 32'(n >= 200), 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_lens.size() != 0 || in_frame || presenting || tx_busy) && n < 30000) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n >= 30000), 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 0; presenting = 0; have_prev = 0; low_cnt = 0;
    end else if (mac_txdv) begin
      if (in_frame) begin
        check("frame_byte_avail", 32'(exp_bytes.size() > 0), 1);
        if (exp_bytes.size() > 0) check("frame_byte", 32'(mac_txd), 32'(exp_bytes.pop_front()));
        rx_cnt++;
      end else begin
        if (!presenting) begin
          presenting = 1;
          check("frame_expected", 32'(exp_lens.size() > 0), 1);
          if (have_prev) begin
            check("ifg_min", 32'(low_cnt >= IFG), 1);
            if (next_queued) check("ifg_max", 32'(low_cnt <= IFG + 3), 1);
          end
        end
        if (exp_bytes.size() > 0) check("byte0_hold", 32'(mac_txd), 32'(exp_bytes[0]));
        if (mac_txack) begin
          if (exp_bytes.size() > 0) void'(exp_bytes.pop_front());
          presenting = 0;
          in_frame   = 1;
          rx_cnt     = 1;
        end
      end
    end else begin
      if (in_frame) begin
        check("frame_len", rx_cnt, exp_lens.size() > 0 ? exp_lens.pop_front() : -1);
        in_frame    = 0;
        have_prev   = 1;
        low_cnt     = 1;
        next_queued = (exp_lens.size() > 0);
      end else if (presenting) begin
        check("present_hold_txdv", 32'(mac_txdv), 1);
        presenting = 0;
      end else begin
        low_cnt++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{len: 64,   err: 1'b0, seed: 0};
    vecs[1]  = '{len: 20,   err: 1'b0, seed: 1};
    vecs[2]  = '{len: 0,    err: 1'b1, seed: 2};
    vecs[3]  = '{len: 1537, err: 1'b1, seed: 3};
    vecs[4]  = '{len: 1,    err: 1'b0, seed: 4};
    vecs[5]  = '{len: 59,   err: 1'b0, seed: 5};
    vecs[6]  = '{len: 60,   err: 1'b0, seed: 6};
    vecs[7]  = '{len: 61,   err: 1'b0, seed: 7};
    vecs[8]  = '{len: 1536, err: 1'b0, seed: 8};
    vecs[9]  = '{len: 300,  err: 1'b0, seed: 9};
    vecs[10] = '{len: 1536, err: 1'b0, seed: 10};

    #23;
    check("rst_txdv", 32'(mac_txdv), 0);
    check("rst_txd", 32'(mac_txd), 0);
    check("rst_commit_err", 32'(commit_err), 0);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_txspace", 32'(packet_txspace), 1);
    check("rst_pending", 32'(pkts_pending), 0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 11; v++) begin
      wait_txspace();
      commit(vecs[v].len, vecs[v].seed, vecs[v].err);
      if (v == 0) begin
        check("first_pending", 32'(pkts_pending), 1);
        check("first_txspace", 32'(packet_txspace), 1);
      end
    end
    drain();
    check("table_pending_end", 32'(pkts_pending), 0);

    // Delayed acknowledge: byte 0 must stay put while the MAC stalls.
    mac_txack = 1'b0;
    commit(64, 11, 1'b0);
    wait_txdv();
    check("ackdly_pending", 32'(pkts_pending), 1);
    check("ackdly_busy", 32'(tx_busy), 1);
    repeat (5) tick();
    check("ackdly_txdv_held", 32'(mac_txdv), 1);
    mac_txack = 1'b1;
    drain();
    check("ackdly_pending_end", 32'(pkts_pending), 0);
    check("ackdly_busy_end", 32'(tx_busy), 0);
    check("ackdly_txspace_end", 32'(packet_txspace), 1);

    // Queue full: eight commits stall behind an unacknowledged frame, the ninth bounces.
    mac_txack = 1'b0;
    for (int k = 0; k < 8; k++) commit(10, 20 + k, 1'b0);
    tick();
    check("qfull_pending", 32'(pkts_pending), 8);
    check("qfull_txspace", 32'(packet_txspace), 0);
    commit(10, 30, 1'b1);
    tick();
    check("qfull_pending_after_reject", 32'(pkts_pending), 8);
    mac_txack = 1'b1;
    drain();
    check("qfull_pending_end", 32'(pkts_pending), 0);

    // Move the write base to 4090 so the next packet straddles the RAM end.
    begin
      int fill;
      fill = (4090 - (wb % 4096) + 4096) % 4096;
      while (fill > 0) begin
        int l;
        l = (fill > MAX_LEN) ? MAX_LEN : fill;
        wait_txspace();
        commit(l, 40, 1'b0);
        fill -= l;
      end
    end
    wait_txspace();
    commit(100, 41, 1'b0);
    drain();

    // Reset in the middle of a long frame.
    commit(200, 50, 1'b0);
    wait_txdv();
    repeat (30) tick();
    #2;
    reset_n = 1'b0;
    exp_bytes.delete();
    exp_lens.delete();
    in_frame = 0; presenting = 0; have_prev = 0; low_cnt = 0;
    wb = 0;
    #1;
    check("midrst_txdv", 32'(mac_txdv), 0);
    check("midrst_txd", 32'(mac_txd), 0);
    check("midrst_pending", 32'(pkts_pending), 0);
    check("midrst_busy", 32'(tx_busy), 0);
    check("midrst_txspace", 32'(packet_txspace), 1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    commit(64, 51, 1'b0);
    drain();
    check("final_pending", 32'(pkts_pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gbe_txpacketbuf_param.md
Name: gbe_txpacketbuf_param

Overview:
Parametrised next-generation GbE transmit packet buffer. Packet builders write bytes at random offsets into a circular byte RAM and commit whole packets with a length. The block queues committed packets, streams each to the MAC over the txdv/txack byte interface, optionally zero-pads short frames, and enforces an inter-packet gap. Unlike the first-generation buffer, it reports write-side free space, rejects illegal or overflowing commits, and exposes status counters.

Parameters:
ADDR_W, 12, log2 of byte RAM depth (DEPTH = 2^ADDR_W).
LEN_W, 11, width of packet length and offset fields.
QLOG2, 3, log2 of the committed-packet length queue depth.
MAX_LEN, 1536, largest legal packet length; also the free-space threshold for packet_txspace.
PAD_EN, 1, when 1, pad packets shorter than MIN_LEN with 0x00 bytes.
MIN_LEN, 60, minimum frame length when PAD_EN=1.
IFG_CYCLES, 12, idle cycles forced between packets (0 allowed).

Ports:
mac_clk  in  1  sole clock.
reset_n  in  1  asynchronous, active-low reset.
packet_txd  in  8  write byte.
packet_addr  in  LEN_W  byte offset within the packet being built.
packet_we  in  1  write strobe.
packet_len  in  LEN_W  length, sampled on packet_done.
packet_done  in  1  single-cycle commit pulse.
packet_txspace  out  1  queue not full AND free bytes >= MAX_LEN.
commit_err  out  1  one-cycle pulse when a commit is rejected.
pkts_pending  out  QLOG2+1  number of committed, unsent packets.
mac_txd  out  8  transmit byte.
mac_txdv  out  1  transmit valid.
mac_txack  in  1  MAC accepts the first byte.
tx_busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-packet): all pointers, queue, and counters 0; mac_txdv=0; mac_txd=0; commit_err=0; tx_busy=0; packet_txspace=1. RAM contents are not cleared.
- Pointers wr_base and rd_base are ADDR_W+1 bits. Used bytes = wr_base - rd_base (modular). Free bytes = DEPTH - used.
- Write path: registered one cycle. RAM[(wr_base + packet_addr) mod DEPTH] <= packet_txd when packet_we is high. Wrap-around is handled by ADDR_W-bit truncation.
- Commit on packet_done:
  - Rejected, with commit_err pulsed the next cycle and no state changed, if packet_len==0, packet_len>MAX_LEN, the queue is full, or packet_len>free.
  - Otherwise packet_len is pushed to the queue and wr_base += packet_len.
- Writes issued while packet_txspace=0 are not protected; the writer checks packet_txspace before building a packet.
- RAM read has 1-cycle latency.
- Transmit FSM:
  - IDLE: mac_txdv=0. If the queue is non-empty, latch len=head and go to PREFETCH.
  - PREFETCH: one cycle for the RAM read; go to PRESENT.
  - PRESENT: mac_txdv=1, mac_txd=byte 0. Hold both until mac_txack=1. On the cycle mac_txack=1, byte 0 is consumed; go to BYTES.
  - BYTES: one byte per cycle, no back-pressure, txdv held 1.
    - Bytes index < len come from RAM.
    - Bytes with len <= index < MIN_LEN are 0x00 when PAD_EN=1.
    - Total bytes sent = max(len, MIN_LEN) if PAD_EN=1, else len.
    - The cycle after the last byte: mac_txdv=0, pop the queue, rd_base += len (pad bytes do not consume RAM), go to GAP.
  - GAP: count IFG_CYCLES cycles with txdv=0, then return to IDLE. If IFG_CYCLES=0, go directly to IDLE.
- A commit and a release in the same cycle both take effect; pkts_pending and free bytes are net-correct.
- A packet of len 1 goes PRESENT -> (ack) -> GAP, with txdv low the cycle after the ack (padding applies if PAD_EN=1).
- mac_txack is ignored outside PRESENT.
- packet_txspace is registered and updates the cycle after any commit or release.

Test Plan:
- Single 64-byte packet with bytes i=0..63 = i, done with len=64, ack held high -> mac_txd 00..3F on 64 consecutive txdv cycles, then txdv=0, 12 idle cycles, pkts_pending 1 -> 0.
- PAD_EN=1, len=20 -> 60 bytes out: 20 data bytes followed by 40 bytes of 0x00; rd_base advances by 20 only.
- Ack delayed 5 cycles -> txdv=1 with byte 0 stable throughout the wait; byte 1 appears the cycle after the ack.
- Commit 8 packets with no ack, then a 9th -> commit_err pulses, pkts_pending=8, packet_txspace=0; ack all -> 8 frames emitted in order.
- Commits with len=0 and len=1537 -> commit_err each time, no pointer change. Packets spanning the RAM end (wr_base=4090, len=100) -> contiguous correct data out.
- reset_n asserted mid-BYTES -> txdv drops asynchronously, pkts_pending=0; after release, a new packet transmits correctly from offset 0.
